debounce_sync: RTL and testbench
================================

// Module: debounce_sync
// PURPOSE
//  Conditions a raw asynchronous level (button, strap, slow external line) into a clean,
//  glitch-free synchronous level plus one-cycle rise/fall pulses.
//  Sits directly upstream of the dual-edge detector: `level` is its intended input.
//  `rise`/`fall` give the same events already split by direction.
//  Flow: N-flop synchronizer -> consecutive-cycle qualification counter -> 4-state FSM.
// PARAMETERS
//  SYNC_STAGES      2     synchronizer depth, >=2
//  DEBOUNCE_CYCLES  1000  consecutive sampled cycles a new value must hold before `level` follows; >=2
//  CNT_W            16    counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//  RESET_VAL        1'b0  value of sync flops and `level` after reset
// PORTS
//  clk       in   1  clock, rising edge
//  rst       in   1  synchronous, active-high reset
//  in_async  in   1  raw input, asynchronous to clk
//  en        in   1  qualification enable; 0 = freeze `level`, clear qualification
//  level     out  1  debounced level (registered)
//  rise      out  1  one-cycle pulse, same edge `level` goes 0->1
//  fall      out  1  one-cycle pulse, same edge `level` goes 1->0
//  busy      out  1  1 while a candidate change is being qualified (state is WAIT_*)
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - sync flops = RESET_VAL; level = RESET_VAL; rise = fall = busy = 0; cnt = 0.
//   - state = IDLE_HI if RESET_VAL else IDLE_LO.
//   - Reset mid-qualification aborts the qualification; no pulse is emitted.
//  sync_q = last synchronizer flop. The synchronizer runs whenever rst=0, regardless of en.
//  FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
//   - IDLE_x: if sync_q != level -> WAIT_y, cnt <= 1. Else hold, cnt = 0.
//   - WAIT_y, sync_q == level (bounce): -> IDLE_x, cnt <= 0. No partial credit, no decrement.
//   - WAIT_y, sync_q != level, cnt == DEBOUNCE_CYCLES-1:
//       level <= ~level; rise or fall <= 1; -> IDLE_y; cnt <= 0.
//   - WAIT_y otherwise: cnt <= cnt+1.
//  Net effect: `level` toggles on the DEBOUNCE_CYCLES-th consecutive edge with sync_q != level.
//  Latency: a clean step on in_async reaches `level` after SYNC_STAGES + DEBOUNCE_CYCLES edges.
//  rise/fall:
//   - Registered; default 0 every cycle; never both 1.
//   - At most one pulse per DEBOUNCE_CYCLES cycles.
//  busy: registered; 1 exactly while state is WAIT_*.
//  en = 0:
//   - level held; FSM forced to IDLE_<level>; cnt <= 0; busy <= 0; no pulses.
//   - After re-enable, qualification restarts from zero.
//  Simultaneous events: rst overrides en; en=0 overrides a qualification completing the same cycle.
//  Counter: unsigned CNT_W bits; never exceeds DEBOUNCE_CYCLES-1; no wrap reachable.
//  Illegal state encoding: recover to IDLE_<level>, cnt <= 0.
// STRUCTURE
//  Shared package bb_pkg:
//   - 2-bit state encodings, Gray order: IDLE_LO=00, WAIT_HI=01, IDLE_HI=11, WAIT_LO=10.
//  Sub-module sync_ff #(STAGES, RESET_VAL) (clk, rst, d, q):
//   - plain flop chain, synchronous active-high reset.
//   - Reused by other CDC inputs in the codebase.
//  Counter, FSM and output registers live in debounce_sync itself.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=0 unless noted)
//  1. rst=1 for 3 edges with in_async=1 -> level=rise=fall=busy=0.
//     Release, hold in_async=1 -> level=1 and rise=1 at 6th edge after release; rise=0 next edge.
//  2. Stable 0; in_async=1 for 3 cycles then 0 -> busy=1 for 3 cycles; level stays 0; no rise.
//  3. level=1 stable; in_async=0 held -> fall pulses once, level=0, 6 edges after the change.
//  4. Drop en for 1 cycle at cnt=2, in_async still 1 -> busy=0, cnt=0.
//     After en=1, rise comes 4 edges after re-enable (full requalification).
//  5. Assert rst while busy=1 (cnt=3) -> next edge level=0, busy=0, no rise/fall at any point.
//  6. RESET_VAL=1 instance: after reset level=1; in_async=0 held -> fall at 6th edge; rise never seen.

Source files
------------

// File: rtl/bb_pkg.sv
// Shared building-block definitions: debounce FSM state encodings.
package bb_pkg;

   localparam logic [1:0] IDLE_LO = 2'b00;
   localparam logic [1:0] WAIT_HI = 2'b01;
   localparam logic [1:0] IDLE_HI = 2'b11;
   localparam logic [1:0] WAIT_LO = 2'b10;

   function automatic logic [1:0] idle_of(input logic lvl);
      return lvl ? IDLE_HI : IDLE_LO;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Plain flop chain synchronizer for a single asynchronous bit.
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) chain <= {STAGES{RESET_VAL}};
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw level; emits a clean level plus rise/fall pulses.
module debounce_sync
   import bb_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 1000,
   parameter int   CNT_W           = 16,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic in_async,
   input  logic en,
   output logic level,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic             sync_q;
   logic [1:0]       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             level_d, rise_d, fall_d;
   logic             diff;

   sync_ff #(
      .STAGES   (SYNC_STAGES),
      .RESET_VAL(RESET_VAL)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (in_async),
      .q  (sync_q)
   );

   assign diff = sync_q != level;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      level_d = level;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (!en) begin
         state_d = idle_of(level);
         cnt_d   = '0;
      end else begin
         case (state)
            IDLE_LO, IDLE_HI: begin
               if (diff) begin
                  state_d = level ? WAIT_LO : WAIT_HI;
                  cnt_d   = ONE;
               end else begin
                  cnt_d   = '0;
               end
            end
            WAIT_HI, WAIT_LO: begin
               if (!diff) begin
                  state_d = idle_of(level);
                  cnt_d   = '0;
               end else if (cnt == LAST) begin
                  level_d = ~level;
                  rise_d  = ~level;
                  fall_d  = level;
                  state_d = idle_of(~level);
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt + ONE;
               end
            end
            default: begin
               state_d = idle_of(level);
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= idle_of(RESET_VAL);
         cnt   <= '0;
         level <= RESET_VAL;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         level <= level_d;
         rise  <= rise_d;
         fall  <= fall_d;
         // Gray encoding: WAIT states are the ones whose two bits differ.
         busy  <= state_d[1] ^ state_d[0];
      end
   end

endmodule

// File: tb/tb_debounce_sync.sv
// Randomized scoreboard bench for debounce_sync, RESET_VAL=0 and RESET_VAL=1 instances.
module tb_debounce_sync;

   localparam int SS = 2;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic rst, en, in_async;
   logic level0, rise0, fall0, busy0;
   logic level1, rise1, fall1, busy1;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_q[$];

   logic m_sh[2][$];
   logic m_lvl[2];
   int   m_run[2];
   logic m_rise[2], m_fall[2], m_busy[2];

   always #5 clk = ~clk;

   debounce_sync #(
      .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(16), .RESET_VAL(1'b0)
   ) dut0 (
      .clk(clk), .rst(rst), .in_async(in_async), .en(en),
      .level(level0), .rise(rise0), .fall(fall0), .busy(busy0)
   );

   debounce_sync #(
      .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(16), .RESET_VAL(1'b1)
   ) dut1 (
      .clk(clk), .rst(rst), .in_async(in_async), .en(en),
      .level(level1), .rise(rise1), .fall(fall1), .busy(busy1)
   );

   // Reference: synchronizer as a delay line, debounce as a run of
   // consecutive disagreeing samples that must reach DC.
   task automatic model_step(input int k, input logic rv,
                             input logic r, input logic e, input logic d);
      logic old;
      m_rise[k] = 1'b0;
      m_fall[k] = 1'b0;
      if (r) begin
         m_sh[k].delete();
         for (int i = 0; i < SS; i++) m_sh[k].push_back(rv);
         m_lvl[k] = rv;
         m_run[k] = 0;
      end else begin
         old = m_sh[k][SS-1];
         m_sh[k].push_front(d);
         void'(m_sh[k].pop_back());
         if (!e || old == m_lvl[k]) begin
            m_run[k] = 0;
         end else begin
            m_run[k]++;
            if (m_run[k] == DC) begin
               if (m_lvl[k]) m_fall[k] = 1'b1;
               else          m_rise[k] = 1'b1;
               m_lvl[k] = ~m_lvl[k];
               m_run[k] = 0;
            end
         end
      end
      m_busy[k] = m_run[k] > 0;
   endtask

   task automatic step(input logic r, input logic e, input logic d);
      @(negedge clk);
      rst = r;
      en = e;
      in_async = d;
      model_step(0, 1'b0, r, e, d);
      model_step(1, 1'b1, r, e, d);
      exp_q.push_back({m_lvl[1], m_rise[1], m_fall[1], m_busy[1],
                       m_lvl[0], m_rise[0], m_fall[0], m_busy[0]});
   endtask

   task automatic hold(input int n, input logic e, input logic d);
      for (int i = 0; i < n; i++) step(1'b0, e, d);
   endtask

   initial begin : monitor
      logic [7:0] e;
      logic [3:0] a0, a1;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a0 = {level0, rise0, fall0, busy0};
            a1 = {level1, rise1, fall1, busy1};
            checks++;
            if (a0 !== e[3:0]) begin
               failures++;
               $display("FAIL outs_rv0 t=%0t got lvl/rise/fall/busy=%b want=%b",
                        $time, a0, e[3:0]);
            end
            checks++;
            if (a1 !== e[7:4]) begin
               failures++;
               $display("FAIL outs_rv1 t=%0t got lvl/rise/fall/busy=%b want=%b",
                        $time, a1, e[7:4]);
            end
            checks++;
            if ((rise0 && fall0) || (rise1 && fall1)) begin
               failures++;
               $display("FAIL pulse_excl t=%0t got r0f0=%b%b r1f1=%b%b want no both",
                        $time, rise0, fall0, rise1, fall1);
            end
         end
      end
   end

   initial begin : driver
      rst = 1'b1;
      en = 1'b1;
      in_async = 1'b0;
      // reset with input high, then release and hold
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
      hold(8, 1'b1, 1'b1);
      hold(8, 1'b1, 1'b0);
      // short glitch must not qualify
      hold(3, 1'b1, 1'b1);
      hold(6, 1'b1, 1'b0);
      // clean rise then fall
      hold(10, 1'b1, 1'b1);
      hold(10, 1'b1, 1'b0);
      // enable dropped mid-qualification
      hold(4, 1'b1, 1'b1);
      hold(1, 1'b0, 1'b1);
      hold(8, 1'b1, 1'b1);
      hold(8, 1'b1, 1'b0);
      // reset mid-qualification
      hold(5, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      hold(8, 1'b1, 1'b0);
      // fresh reset, input held low (RESET_VAL=1 instance falls)
      step(1'b1, 1'b1, 1'b0);
      hold(10, 1'b1, 1'b0);
      // randomized bouncing traffic
      begin
         logic d, e, r;
         d = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) d = ~d;
            e = $urandom_range(0, 39) != 0;
            r = $urandom_range(0, 299) == 0;
            step(r, e, d);
         end
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d pending want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
